// File: rtl/spy_meter_pkg.sv
// Shared types and defaults for the spy path delay meter.
package spy_meter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StSettle,
    StDone
  } meter_state_e;

  localparam int unsigned DefaultTimeout = 1023;
  localparam int unsigned DefaultSettle  = 4;
  // Two synchronizer stages sit between the path output and the FSM.
  localparam int unsigned MinLatency     = 2;

endpackage

// File: rtl/spy_path_delay_meter_if.sv
// Control, path and result signals of the spy path delay meter.
interface spy_path_delay_meter_if #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TRIAL_W = 8
);
  logic                     start;
  logic [TRIAL_W-1:0]       numTrials;
  logic                     pathInput;
  logic                     pathResult;
  logic                     busy;
  logic                     done;
  logic                     timeoutErr;
  logic [CNT_W-1:0]         lastLatency;
  logic [CNT_W-1:0]         minLatency;
  logic [CNT_W-1:0]         maxLatency;
  logic [CNT_W+TRIAL_W-1:0] sumLatency;

  modport master (
    output start, numTrials, pathResult,
    input  pathInput, busy, done, timeoutErr,
    input  lastLatency, minLatency, maxLatency, sumLatency
  );

  modport slave (
    input  start, numTrials, pathResult,
    output pathInput, busy, done, timeoutErr,
    output lastLatency, minLatency, maxLatency, sumLatency
  );
endinterface

// File: rtl/spy_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module spy_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spy_path_delay_meter.sv
// Launches transitions into a chained delay path and measures arrival latency in clk cycles.
module spy_path_delay_meter
  import spy_meter_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TRIAL_W   = 8,
  parameter int unsigned TIMEOUT   = DefaultTimeout,
  parameter int unsigned SETTLE    = DefaultSettle,
  parameter int unsigned INVERTING = 0
) (
  input logic                   clk,
  input logic                   rst,
  spy_path_delay_meter_if.slave bus
);
  localparam int unsigned SumW = CNT_W + TRIAL_W;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  meter_state_e       state;
  logic [TRIAL_W-1:0] trials_left;
  logic [CNT_W-1:0]   cnt;
  logic [SetW-1:0]    settle_cnt;
  logic               rs;
  logic               expected;

  spy_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pathResult),
    .q   (rs)
  );

  assign expected = bus.pathInput ^ INVERTING[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      trials_left     <= '0;
      cnt             <= '0;
      settle_cnt      <= '0;
      bus.pathInput   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeoutErr  <= 1'b0;
      bus.lastLatency <= '0;
      bus.minLatency  <= '0;
      bus.maxLatency  <= '0;
      bus.sumLatency  <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            trials_left    <= (bus.numTrials == '0) ? TRIAL_W'(1) : bus.numTrials;
            bus.minLatency <= '1;
            bus.maxLatency <= '0;
            bus.sumLatency <= '0;
            bus.timeoutErr <= 1'b0;
            bus.busy       <= 1'b1;
            state          <= StLaunch;
          end
        end
        StLaunch: begin
          // pathInput is never returned to 0, so trials alternate edge direction.
          bus.pathInput <= ~bus.pathInput;
          cnt           <= '0;
          state         <= StWait;
        end
        StWait: begin
          // Arrival wins over timeout when both happen on the same count.
          if (rs == expected) begin
            bus.lastLatency <= cnt;
            if (cnt < bus.minLatency) bus.minLatency <= cnt;
            if (cnt > bus.maxLatency) bus.maxLatency <= cnt;
            bus.sumLatency <= bus.sumLatency + SumW'(cnt);
            settle_cnt     <= '0;
            state          <= StSettle;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            bus.timeoutErr <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state          <= StDone;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StSettle: begin
          if (settle_cnt == SetW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            if (trials_left == TRIAL_W'(1)) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= StDone;
            end else begin
              trials_left <= trials_left - TRIAL_W'(1);
              state       <= StLaunch;
            end
          end else begin
            settle_cnt <= settle_cnt + SetW'(1);
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spy_path_delay_meter.sv
// Randomized bench for the spy path delay meter against a time-based path and statistics model.
module tb_spy_path_delay_meter;
  import spy_meter_pkg::*;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TRIAL_W = 8;
  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned SumW    = CNT_W + TRIAL_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spy_path_delay_meter_if #(.CNT_W(CNT_W), .TRIAL_W(TRIAL_W)) bus ();

  spy_path_delay_meter #(
    .CNT_W     (CNT_W),
    .TRIAL_W   (TRIAL_W),
    .TIMEOUT   (TIMEOUT),
    .SETTLE    (SETTLE),
    .INVERTING (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic chk_en = 1'b0;

  // Path model: each launch edge reaches the output plan[trial] cycles later.
  int   plan [64];
  int   base = 0;
  int   ntog = 0;
  int   age = 32'h00ff_ffff;
  int   cur_d = 1;
  logic seen = 1'b0;
  logic prev_v = 1'b0;
  logic stuck = 1'b0;

  always @(posedge clk) begin
    if (bus.pathInput !== seen) begin
      prev_v <= seen;
      seen   <= bus.pathInput;
      age    <= 1;
      cur_d  <= plan[(ntog - base) & 63];
      ntog   <= ntog + 1;
    end else if (age < 32'h00ff_ffff) begin
      age <= age + 1;
    end
  end

  assign bus.pathResult = stuck ? 1'b0 : ((age >= cur_d) ? seen : prev_v);

  // Expected held outputs of the most recent run.
  logic [CNT_W-1:0] exp_last, exp_min, exp_max;
  logic [SumW-1:0]  exp_sum;
  logic             exp_to, exp_pin;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (bus.done) begin
        done_seen <= done_seen + 1;
        chk("busy_low_at_done", 64'(bus.busy), 64'd0);
      end
      if (bus.done || !bus.busy) begin
        chk("pin_held", 64'(bus.pathInput), 64'(exp_pin));
        chk("last_held", 64'(bus.lastLatency), 64'(exp_last));
        chk("min_held", 64'(bus.minLatency), 64'(exp_min));
        chk("max_held", 64'(bus.maxLatency), 64'(exp_max));
        chk("sum_held", 64'(bus.sumLatency), 64'(exp_sum));
        chk("timeout_held", 64'(bus.timeoutErr), 64'(exp_to));
      end
    end
  end

  task automatic clear_model();
    exp_last = '0;
    exp_min  = '0;
    exp_max  = '0;
    exp_sum  = '0;
    exp_to   = 1'b0;
    exp_pin  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic do_run(input int ntr, input bit extra);
    int eff, lat, tog, budget, lo, hi, k, ds0;
    int m_last, m_min, m_max, m_sum;
    bit m_to, got;
    eff    = (ntr == 0) ? 1 : ntr;
    m_last = int'(exp_last);
    m_min  = 'hFFFF;
    m_max  = 0;
    m_sum  = 0;
    m_to   = 1'b0;
    tog    = 0;
    budget = 40;
    for (int i = 0; i < eff; i++) begin
      tog = tog + 1;
      lat = stuck ? int'(TIMEOUT) + 1 : plan[i] + int'(MinLatency);
      budget = budget + ((lat > int'(TIMEOUT)) ? int'(TIMEOUT) + 1 : lat) + int'(SETTLE) + 4;
      if (lat > int'(TIMEOUT)) begin
        m_to = 1'b1;
        break;
      end
      m_last = lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
      m_sum = m_sum + lat;
    end
    lo = m_sum + eff * (1 + int'(SETTLE));
    hi = m_sum + eff * (2 + int'(SETTLE)) + 2;

    base = ntog;
    ds0  = done_seen;
    @(negedge clk);
    bus.numTrials = TRIAL_W'(ntr);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.numTrials = TRIAL_W'($urandom_range(1, 200));
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    exp_last = CNT_W'(m_last);
    exp_min  = CNT_W'(m_min);
    exp_max  = CNT_W'(m_max);
    exp_sum  = SumW'(m_sum);
    exp_to   = m_to;
    exp_pin  = exp_pin ^ tog[0];

    k   = 0;
    got = 1'b0;
    while (k < budget) begin
      @(negedge clk);
      k = k + 1;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      bus.start = extra && (k == 3);
      if (extra && (k == 3)) bus.numTrials = TRIAL_W'($urandom_range(2, 9));
    end
    bus.start = 1'b0;
    chk("run_done_in_budget", 64'(got), 64'd1);
    if (got && !m_to) chk("done_cycle_window", 64'((k >= lo) && (k <= hi)), 64'd1);
    repeat (3) @(negedge clk);
    chk("single_done_pulse", 64'(done_seen - ds0), 64'd1);
  endtask

  task automatic pin_lits(input string nm, input int l, input int mn, input int mx,
                          input int sm, input bit to, input bit pin);
    chk({nm, "_last"}, 64'(bus.lastLatency), 64'(l));
    chk({nm, "_min"}, 64'(bus.minLatency), 64'(mn));
    chk({nm, "_max"}, 64'(bus.maxLatency), 64'(mx));
    chk({nm, "_sum"}, 64'(bus.sumLatency), 64'(sm));
    chk({nm, "_timeout"}, 64'(bus.timeoutErr), 64'(to));
    chk({nm, "_pin"}, 64'(bus.pathInput), 64'(pin));
  endtask

  initial begin
    int n;
    bit hit;
    bus.start     = 1'b0;
    bus.numTrials = '0;
    for (int i = 0; i < 64; i++) plan[i] = 10;
    clear_model();
    repeat (3) @(negedge clk);
    pin_lits("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    do_run(1, 1'b0);
    pin_lits("single_d10", 12, 12, 12, 12, 1'b0, 1'b1);

    // Reset in the WAIT phase of the second trial.
    base = ntog;
    n = done_seen;
    @(negedge clk);
    bus.numTrials = TRIAL_W'(4);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ntog - base >= 2) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("second_launch_seen", 64'(hit), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    pin_lits("async_reset", 0, 0, 0, 0, 1'b0, 1'b0);
    chk("async_reset_busy", 64'(bus.busy), 64'd0);
    chk("async_reset_done", 64'(bus.done), 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 64'(done_seen - n), 64'd0);
    do_run(1, 1'b0);
    pin_lits("after_reset", 12, 12, 12, 12, 1'b0, 1'b1);

    do_reset();
    do_run(4, 1'b0);
    pin_lits("four_d10", 12, 12, 12, 48, 1'b0, 1'b0);

    stuck = 1'b1;
    do_run(2, 1'b0);
    stuck = 1'b0;
    pin_lits("stuck", 12, 'hFFFF, 0, 0, 1'b1, 1'b1);

    plan[0] = 5;
    plan[1] = 9;
    plan[2] = 5;
    do_run(3, 1'b0);
    pin_lits("alt_5_9", 7, 7, 11, 25, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++) plan[i] = 10;
    do_run(0, 1'b1);
    pin_lits("zero_trials", 12, 12, 12, 12, 1'b0, 1'b1);

    plan[0] = 1021;
    do_run(1, 1'b0);
    pin_lits("arrive_at_timeout", 1023, 1023, 1023, 1023, 1'b0, 1'b0);

    plan[0] = 1022;
    do_run(1, 1'b0);
    pin_lits("past_timeout", 1023, 'hFFFF, 0, 0, 1'b1, 1'b1);

    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 8; i++) plan[i] = $urandom_range(1, 40);
      do_run($urandom_range(0, 6), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
